// File: rtl/ysyx_25060170_ctrl.sv
// Multi-cycle core controller: sequences fetch/decode/exec/mem/writeback,
// with bounded handshake waits, sticky halt/error states and perf counters.
module ysyx_25060170_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  input  logic        dec_regw,
  input  logic [1:0]  dec_regs,
  input  logic        dec_memwr,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_done,
  output logic        gpr_we,
  output logic        pc_we,
  output logic        halt_o,
  output logic        err_o,
  output logic [31:0] cycle_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] wait_cnt;
  logic          wait_tick;
  logic          is_mem;

  assign is_mem = (dec_regs == 2'd1) || dec_memwr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // The last permitted wait cycle still accepts a handshake; only its absence errors.
  always_comb begin
    nxt       = state;
    wait_tick = 1'b0;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH: begin
        if (ifu_rvalid)                nxt = (inst_i == EBREAK) ? S_HALT : S_DECODE;
        else if (wait_cnt == WAIT_LAST) nxt = S_ERROR;
        else                           wait_tick = 1'b1;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_done)                  nxt = S_WB;
        else if (wait_cnt == WAIT_LAST) nxt = S_ERROR;
        else                           wait_tick = 1'b1;
      end
      S_WB:     nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  // Strobes are registered from the next-state decode so they line up with WB/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      inst_o    <= '0;
      cycle_o   <= '0;
      instret_o <= '0;
      pc_we     <= 1'b0;
      gpr_we    <= 1'b0;
      lsu_we    <= 1'b0;
    end else begin
      cycle_o <= cycle_o + 32'd1;
      if (nxt != state)   wait_cnt <= '0;
      else if (wait_tick) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_FETCH && ifu_rvalid) inst_o <= inst_i;
      if (state == S_WB) instret_o <= instret_o + 32'd1;
      pc_we  <= (nxt == S_WB);
      gpr_we <= (nxt == S_WB) && dec_regw && (inst_o[11:7] != 5'd0);
      lsu_we <= (nxt == S_MEM) && dec_memwr;
    end
  end

  assign ifu_req = (state == S_FETCH);
  assign lsu_req = (state == S_MEM);
  assign halt_o  = (state == S_HALT);
  assign err_o   = (state == S_ERROR);
  assign state_o = state;

endmodule

// File: doc/ysyx_25060170_ctrl.md
YSYX_25060170_CTRL -- requirements
Module: ysyx_25060170_ctrl

Interface
REQ-001 SHALL expose parameter TIMEOUT, default 255, meaning max wait cycles in FETCH/MEM before error.
REQ-002 SHALL expose: clk  in  1  core clock (rising edge).
REQ-003 SHALL expose: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL expose: ifu_req  out  1  fetch request to IFU.
REQ-005 SHALL expose: ifu_rvalid  in  1  fetched instruction valid.
REQ-006 SHALL expose: inst_i  in  32  instruction from IFU.
REQ-007 SHALL expose: inst_o  out  32  latched instruction register to IDU.
REQ-008 SHALL expose: dec_regw  in  1  IDU register-write enable.
REQ-009 SHALL expose: dec_regs  in  2  IDU writeback select; 1 = load.
REQ-010 SHALL expose: dec_memwr  in  1  IDU store indication.
REQ-011 SHALL expose: lsu_req, lsu_we  out  1 each  memory access request and write strobe.
REQ-012 SHALL expose: lsu_done  in  1  memory access complete.
REQ-013 SHALL expose: gpr_we, pc_we  out  1 each  GPR and PC commit strobes.
REQ-014 SHALL expose: halt_o, err_o  out  1 each  sticky ebreak halt and sticky timeout error.
REQ-015 SHALL expose: cycle_o, instret_o  out  32 each  cycle and retired-instruction counters.
REQ-016 SHALL expose: state_o  out  3  current FSM state encoding.

Function
REQ-017 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 FETCH SHALL hold ifu_req=1 each cycle until ifu_rvalid=1; on that edge, latch inst_i into inst_o and go to DECODE.
REQ-020 On ifu_rvalid with inst_i=0x00100073 (ebreak), SHALL latch inst_o and go to HALT instead of DECODE.
REQ-021 DECODE and EXEC SHALL each last exactly one cycle.
REQ-022 On leaving EXEC: load (dec_regs=1) or store (dec_memwr=1) goes to MEM; otherwise to WB.
REQ-023 MEM SHALL hold lsu_req=1 and lsu_we=dec_memwr until lsu_done=1, then go to WB; lsu_we=0 outside MEM.
REQ-024 WB SHALL last one cycle and assert pc_we=1, gpr_we=dec_regw AND (inst_o[11:7]!=0), increment instret_o, then go to FETCH.
REQ-025 Minimum latency: ALU instruction 4 cycles FETCH-to-WB with ifu_rvalid on the first FETCH cycle; load/store +1 + lsu wait.
REQ-026 A wait counter SHALL reset on entering FETCH or MEM and count each waiting cycle; reaching TIMEOUT without handshake goes to ERROR.
REQ-027 A handshake arriving in the same cycle the counter reaches TIMEOUT SHALL win; no ERROR.
REQ-028 HALT and ERROR SHALL be terminal until reset; halt_o=1 in HALT, err_o=1 in ERROR, all request/strobe outputs 0.
REQ-029 cycle_o SHALL increment every cycle outside reset, including HALT/ERROR, wrapping 0xFFFFFFFF->0.
REQ-030 instret_o SHALL wrap 0xFFFFFFFF->0; it SHALL NOT count the ebreak.
REQ-031 ifu_rvalid outside FETCH and lsu_done outside MEM SHALL be ignored.
REQ-032 All outputs SHALL be registered state or decodes of state only; no combinational path from inputs to ifu_req/lsu_req.

Reset
REQ-033 rst_n low SHALL immediately, independent of clk, force state IDLE, inst_o=0, counters=0, every 1-bit output 0.
REQ-034 Reset asserted mid-FETCH or mid-MEM SHALL abort the transaction; no gpr_we/pc_we pulse SHALL follow release.
REQ-035 Reset release SHALL be synchronous to clk for state update.

Verification
REQ-036 addi, ifu_rvalid on first FETCH cycle, dec_regw=1, rd=5 -> gpr_we and pc_we pulse 4 cycles after FETCH entry; instret_o=1.
REQ-037 lw, lsu_done 3 cycles after MEM entry -> lsu_req high 3 cycles, lsu_we=0, gpr_we pulse next cycle.
REQ-038 sw, dec_memwr=1, dec_regw=0 -> lsu_we=1 during MEM, gpr_we stays 0, pc_we pulses.
REQ-039 Fetch 0x00100073 -> state_o=6, halt_o=1, instret_o unchanged, cycle_o still counting.
REQ-040 ifu_rvalid held 0 for TIMEOUT cycles -> state_o=7, err_o=1; repeat with rvalid on the TIMEOUT cycle -> DECODE, no error.
REQ-041 rst_n pulsed low mid-MEM -> outputs 0 asynchronously; after release IDLE then FETCH; instret_o=0.
